// File: rtl/score_bcd_accumulator.sv
// Six-digit BCD score accumulator: line-clear events are multiplied by (level+1)
// through repeated BCD additions; soft drops add one point. Optional SCORE_HISCORE_EN.
module score_bcd_accumulator #(
  parameter int unsigned LEVEL_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               game_reset,
  input  logic               clear_valid,
  input  logic [2:0]         lines_cleared,
  input  logic [LEVEL_W-1:0] level,
  output logic               add_ready,
  input  logic               drop_pulse,
  output logic [23:0]        score_digits,
  output logic               saturated
`ifdef SCORE_HISCORE_EN
  ,
  output logic [23:0]        hiscore_digits
`endif
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state_q, state_d;
  logic [1:0]         pending_q, pending_d;
  logic [LEVEL_W-1:0] iter_q, iter_d;
  logic [23:0]        base_q, base_d;
  logic [23:0]        score_q, score_d;
  logic               sat_q, sat_d;

  logic        accept;
  logic        apply;
  logic        lines_ok;
  logic [2:0]  pend_sum;
  logic [23:0] addend;
  logic [24:0] add_res;
  logic [23:0] score_inc;

  function automatic logic [24:0] bcd_add(input logic [23:0] a, input logic [23:0] b);
    logic [4:0]  s;
    logic        c;
    logic [23:0] r;
    c = 1'b0;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  assign add_ready    = (state_q == IDLE) && (pending_q == 2'd0);
  assign score_digits = score_q;
  assign saturated    = sat_q;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    base_d  = base_q;
    score_d = score_q;
    sat_d   = sat_q;

    accept   = clear_valid && add_ready;
    lines_ok = (lines_cleared != 3'd0) && (lines_cleared <= 3'd4);
    apply    = (state_q == IDLE) && !accept && ((pending_q != 2'd0) || drop_pulse);

    // apply implies pending!=0 or a drop this cycle, so the sum never underflows
    pend_sum  = {1'b0, pending_q} + {2'b0, drop_pulse} - {2'b0, apply};
    pending_d = (pend_sum > 3'd3) ? 2'd3 : pend_sum[1:0];

    addend    = (state_q == ACCUM) ? base_q : 24'h000001;
    add_res   = bcd_add(score_q, addend);
    score_inc = (add_res[24] || sat_q) ? 24'h999999 : add_res[23:0];

    case (state_q)
      ACCUM: begin
        score_d = score_inc;
        sat_d   = sat_q | add_res[24];
        if (iter_q == '0) state_d = IDLE;
        else              iter_d  = iter_q - 1'b1;
      end
      default: begin
        if (accept) begin
          if (lines_ok) begin
            case (lines_cleared)
              3'd1:    base_d = 24'h000040;
              3'd2:    base_d = 24'h000100;
              3'd3:    base_d = 24'h000300;
              default: base_d = 24'h001200;
            endcase
            iter_d  = level;
            state_d = ACCUM;
          end
        end else if (apply) begin
          score_d = score_inc;
          sat_d   = sat_q | add_res[24];
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || game_reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      iter_q    <= '0;
      base_q    <= '0;
      score_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      iter_q    <= iter_d;
      base_q    <= base_d;
      score_q   <= score_d;
      sat_q     <= sat_d;
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [23:0] hiscore_q;

  // BCD digits order the same as binary, so a plain unsigned compare suffices
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hiscore_q <= '0;
    end else if (game_reset && (score_q > hiscore_q)) begin
      hiscore_q <= score_q;
    end
  end

  assign hiscore_digits = hiscore_q;
`endif

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Directed bench for score_bcd_accumulator: per-cycle vector table plus
// hand sequences for mid-accumulation game reset and saturation.
module tb_score_bcd_accumulator;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        game_reset;
  logic        clear_valid;
  logic [2:0]  lines_cleared;
  logic [3:0]  level;
  logic        add_ready;
  logic        drop_pulse;
  logic [23:0] score_digits;
  logic        saturated;
`ifdef SCORE_HISCORE_EN
  logic [23:0] hiscore_digits;
`endif

  score_bcd_accumulator #(.LEVEL_W(4)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .game_reset    (game_reset),
    .clear_valid   (clear_valid),
    .lines_cleared (lines_cleared),
    .level         (level),
    .add_ready     (add_ready),
    .drop_pulse    (drop_pulse),
    .score_digits  (score_digits),
    .saturated     (saturated)
`ifdef SCORE_HISCORE_EN
    ,
    .hiscore_digits(hiscore_digits)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        gr;
    logic        cv;
    logic [2:0]  lines;
    logic [3:0]  lvl;
    logic        drop;
    logic [23:0] score;
    logic        ready;
    logic        sat;
    logic [23:0] hs;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  logic [23:0] model_hs = '0;
  logic [23:0] model_last = '0;

  function automatic logic [23:0] bcd(input int unsigned n);
    logic [23:0] r;
    int unsigned v;
    v = n;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic gr, input logic cv, input logic [2:0] ln,
                       input logic [3:0] lv, input logic dr);
    game_reset    = gr;
    clear_valid   = cv;
    lines_cleared = ln;
    level         = lv;
    drop_pulse    = dr;
  endtask

  task automatic chk_out(input string name, input logic [23:0] sc, input logic rdy,
                         input logic st, input logic [23:0] hs);
    chk({name, ".score"}, score_digits, sc);
    chk({name, ".ready"}, {23'b0, add_ready}, {23'b0, rdy});
    chk({name, ".sat"}, {23'b0, saturated}, {23'b0, st});
`ifdef SCORE_HISCORE_EN
    chk({name, ".hiscore"}, hiscore_digits, hs);
`else
    if (hs == 24'hFFFFFF) $display("unreachable hiscore %h", hs);
`endif
  endtask

  task automatic push(input logic gr, input logic cv, input logic [2:0] ln,
                      input logic [3:0] lv, input logic dr, input int unsigned sc,
                      input logic rdy);
    vec_t v;
    if (gr && (model_last > model_hs)) model_hs = model_last;
    v.gr = gr; v.cv = cv; v.lines = ln; v.lvl = lv; v.drop = dr;
    v.score = bcd(sc); v.ready = rdy; v.sat = 1'b0; v.hs = model_hs;
    model_last = v.score;
    vecs.push_back(v);
  endtask

  initial begin
    string nm;
    drive(0, 0, 0, 0, 0);
    Reset = 1'b1;

    // one line, level 0
    push(0, 1, 1, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 40, 1);
    push(1, 0, 0, 0, 0, 0, 1);
    // tetris at level 2: three additions
    push(0, 1, 4, 2, 0, 0, 0);
    push(0, 0, 0, 0, 0, 1200, 0);
    push(0, 0, 0, 0, 0, 2400, 0);
    push(0, 0, 0, 0, 0, 3600, 1);
    // invalid line counts are consumed as no-ops
    push(0, 1, 0, 5, 0, 3600, 1);
    push(0, 1, 5, 3, 0, 3600, 1);
    push(0, 1, 7, 0, 0, 3600, 1);
    push(0, 0, 0, 0, 1, 3601, 1);
    push(0, 1, 2, 1, 0, 3601, 0);
    push(0, 0, 0, 0, 0, 3701, 0);
    push(0, 0, 0, 0, 0, 3801, 1);
    push(0, 1, 3, 0, 0, 3801, 0);
    push(0, 0, 0, 0, 0, 4101, 1);
    // game reset discards a coincident clear and drop
    push(1, 1, 1, 0, 1, 0, 1);
    push(0, 0, 0, 0, 0, 0, 1);
    // drops queued on accept and during ACCUM
    push(0, 1, 1, 3, 1, 0, 0);
    push(0, 0, 0, 0, 0, 40, 0);
    push(0, 0, 0, 0, 1, 80, 0);
    push(0, 0, 0, 0, 0, 120, 0);
    push(0, 0, 0, 0, 0, 160, 0);
    push(0, 0, 0, 0, 0, 161, 0);
    push(0, 0, 0, 0, 0, 162, 1);
    push(0, 0, 0, 0, 0, 162, 1);
    // pending saturates at 3; two further drops are lost
    push(0, 1, 1, 4, 0, 162, 0);
    push(0, 0, 0, 0, 1, 202, 0);
    push(0, 0, 0, 0, 1, 242, 0);
    push(0, 0, 0, 0, 1, 282, 0);
    push(0, 0, 0, 0, 1, 322, 0);
    push(0, 0, 0, 0, 1, 362, 0);
    push(0, 0, 0, 0, 0, 363, 0);
    push(0, 0, 0, 0, 0, 364, 0);
    push(0, 0, 0, 0, 0, 365, 1);

    tick();
    tick();
    Reset = 1'b0;
    tick();
    chk_out("reset", '0, 1'b1, 1'b0, '0);

    foreach (vecs[i]) begin
      drive(vecs[i].gr, vecs[i].cv, vecs[i].lines, vecs[i].lvl, vecs[i].drop);
      tick();
      nm = $sformatf("vec%0d", i);
      chk_out(nm, vecs[i].score, vecs[i].ready, vecs[i].sat, vecs[i].hs);
    end

    // Reset clears everything including hiscore
    drive(0, 0, 0, 0, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_out("reset2", '0, 1'b1, 1'b0, '0);

    // game reset in the middle of accumulation at 000520
    drive(0, 1, 1, 15, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) tick();
    chk_out("mid520", 24'h000520, 1'b0, 1'b0, '0);
    drive(1, 0, 0, 0, 0);
    tick();
    chk_out("gr520", '0, 1'b1, 1'b0, 24'h000520);
    drive(0, 1, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk_out("game2", 24'h000100, 1'b1, 1'b0, 24'h000520);
    drive(1, 0, 0, 0, 0);
    tick();
    chk_out("gr100", '0, 1'b1, 1'b0, 24'h000520);

    // 52 tetrises at level 15 reach 998400
    for (int t = 1; t <= 52; t++) begin
      drive(0, 1, 4, 15, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < 16; k++) tick();
      chk(.name($sformatf("tetris%0d", t)), .act(score_digits), .exp(bcd(19200 * t)));
    end
    chk_out("pre_sat", 24'h998400, 1'b1, 1'b0, 24'h000520);
    drive(0, 1, 4, 15, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk_out("sat_a1", 24'h999600, 1'b0, 1'b0, 24'h000520);
    tick();
    chk_out("sat_a2", 24'h999999, 1'b0, 1'b1, 24'h000520);
    for (int k = 0; k < 14; k++) tick();
    chk_out("sat_end", 24'h999999, 1'b1, 1'b1, 24'h000520);
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk_out("sat_drop", 24'h999999, 1'b1, 1'b1, 24'h000520);
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk_out("sat_gr", '0, 1'b1, 1'b0, 24'h999999);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_bcd_accumulator.md
Name: score_bcd_accumulator

Overview:
- Upstream producer of the 24-bit, 6-digit BCD score word consumed by the colour mapper's score area. One instance per player.
- Converts line-clear events and soft-drop pulses into score increments.
- Computes the level multiplier by repeated BCD addition rather than a multiplier, one addition per clock.

Parameters:
LEVEL_W, 4, width of level input; multiplier range is 1..2^LEVEL_W

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous active-high reset
game_reset  in  1  synchronous clear of score/state for a new game
clear_valid  in  1  line-clear event request
lines_cleared  in  3  lines cleared by the event, 1..4 valid
level  in  LEVEL_W  current level, sampled on acceptance
add_ready  out  1  block can accept a clear event
drop_pulse  in  1  one soft-drop point, single-cycle pulse
score_digits  out  24  BCD score; [23:20] most significant digit, [3:0] least
saturated  out  1  sticky; score clamped at 999999

Behaviour:
- Reset, and game_reset when Reset is low: all registers clear.
  - score_digits=0, saturated=0, state=IDLE, pending=0, iter=0, base=0.
  - add_ready is 1 from the following cycle.
  - game_reset aborts any accumulation in progress; drops and clears in that cycle are discarded.
- States: IDLE, ACCUM.
  - add_ready = (state==IDLE) && (pending==0). It is a combinational output.
- Acceptance occurs at an edge where clear_valid && add_ready.
  - On that edge, latch base from lines_cleared: 1->000040, 2->000100, 3->000300, 4->001200.
  - Latch iter=level and move to ACCUM.
  - If lines_cleared is 0 or 5..7, the event is consumed as a no-op: stay in IDLE, score unchanged.
- ACCUM: each edge performs score = score + base, using a 6-digit BCD add with a per-digit decimal-adjust carry chain.
  - If iter==0, go to IDLE; otherwise decrement iter.
  - Total additions = level+1, on edges A+1..A+level+1, where A is the acceptance edge.
  - add_ready rises after edge A+level+1, provided pending==0.
  - Inputs lines_cleared and level are ignored during ACCUM.
- Soft drops: pending is a 2-bit counter that saturates at 3.
  - apply = (state==IDLE) && !accept && (pending!=0 || drop_pulse).
  - pending_next = sat3(pending + drop_pulse - apply).
  - When apply is true, score = score + 000001 on that edge.
  - A drop in IDLE with pending==0 and no accept is applied on the same edge and never enters pending.
  - A drop coinciding with an acceptance is queued in pending.
  - Drops arriving while pending==3 are lost.
- Saturation: if any BCD add carries out of digit 5, score_digits=999999 and saturated=1.
  - Subsequent adds keep the score at 999999.
  - Only Reset or game_reset clears saturated.
- Each digit always stays in 0..9; score_digits is registered, with no combinational path from inputs.
- Precedence: Reset > game_reset > ACCUM addition > IDLE acceptance > drop apply.

Optional Feature:
SCORE_HISCORE_EN
- Defined:
  - Adds output port hiscore_digits [23:0], a BCD register.
  - On an edge with game_reset=1 and Reset=0, hiscore_digits takes the current score_digits if score_digits > hiscore_digits. The comparison is unsigned binary, which is valid for BCD.
  - The update happens on the same edge the score clears. hiscore_digits is cleared only by Reset.
- Undefined: the port and register do not exist, and game_reset only clears the score.

Test Plan:
- Reset held 2 cycles, then released -> score_digits=000000, saturated=0, add_ready=1 on the first cycle after release.
- level=0, lines_cleared=1, one-cycle clear_valid -> add_ready low 1 cycle, then score_digits=000040.
- level=2, lines_cleared=4 -> exactly 3 ACCUM cycles; score goes 001200, 002400, 003600; add_ready returns the cycle after.
- level=3, lines_cleared=1, drop_pulse on accept cycle and on 2nd ACCUM cycle -> 160 accumulated, then two IDLE drop applies -> final 000162; add_ready low until pending==0.
- level=15, 52 tetrises -> 998400; 53rd tetris -> 999600 then clamp -> 999999 with saturated=1; further drop_pulse -> stays 999999.
- game_reset asserted mid-ACCUM at score 000520 -> next cycle score 000000, IDLE, add_ready=1. With SCORE_HISCORE_EN, hiscore_digits=000520; a second game_reset at score 000100 leaves hiscore_digits at 000520.
